// File: rtl/ssd_pkg.sv
// ---------------------------------------------------------------------------
// ssd_pkg
//   Shared types and constants for the seven-segment scan controller.
//   - scan_state_e : scan FSM states (idle, blanking gap, digit lit)
//   - SSD_BLANK    : active-low segment pattern with every segment off
// ---------------------------------------------------------------------------
package ssd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_SHOW  = 2'd2
    } scan_state_e;

    localparam logic [6:0] SSD_BLANK = 7'h7F;

endpackage : ssd_pkg

// File: rtl/ssd_scan_ctrl_hex2ssd.sv
// ---------------------------------------------------------------------------
// hex2ssd
//   Combinational hex nibble to seven-segment decoder for common-anode digits.
//   Ports:
//     hex_i  in  4  nibble to display (0..F)
//     ssd_o  out 7  segments GFEDCBA, active-low (0 = segment on)
//   Letters b and d are lower case so they stay distinct from 8 and 0.
// ---------------------------------------------------------------------------
module hex2ssd (
    input  logic [3:0] hex_i,
    output logic [6:0] ssd_o
);

    always_comb begin
        case (hex_i)
            4'h0:    ssd_o = 7'b1000000;
            4'h1:    ssd_o = 7'b1111001;
            4'h2:    ssd_o = 7'b0100100;
            4'h3:    ssd_o = 7'b0110000;
            4'h4:    ssd_o = 7'b0011001;
            4'h5:    ssd_o = 7'b0010010;
            4'h6:    ssd_o = 7'b0000010;
            4'h7:    ssd_o = 7'b1111000;
            4'h8:    ssd_o = 7'b0000000;
            4'h9:    ssd_o = 7'b0010000;
            4'hA:    ssd_o = 7'b0001000;
            4'hB:    ssd_o = 7'b0000011;
            4'hC:    ssd_o = 7'b1000110;
            4'hD:    ssd_o = 7'b0100001;
            4'hE:    ssd_o = 7'b0000110;
            default: ssd_o = 7'b0001110;
        endcase
    end

endmodule : hex2ssd

// File: rtl/ssd_scan_ctrl.sv
// ---------------------------------------------------------------------------
// ssd_scan_ctrl
//   Time-multiplexed scan controller for digits_p common-anode digits sharing
//   one hex2ssd decoder. Each slot starts with a blanking gap (anti-ghosting),
//   then lights one digit. The whole value is snapshotted once per frame so a
//   frame never shows a torn update. Outputs depend on registers only.
//   Ports:
//     clk_i          in   1            clock
//     reset_i        in   1            asynchronous, active-high reset
//     en_i           in   1            scan enable (0 = dark, restart at digit 0)
//     value_i        in   4*digits_p   packed nibbles, digit 0 = value_i[3:0]
//     dp_i           in   digits_p     decimal point request per digit
//     lz_suppress_i  in   1            blank leading zero digits
//     ssd_o          out  7            segments GFEDCBA, active-low
//     dp_o           out  1            decimal point, active-low
//     an_o           out  digits_p     anode select, active-low, one-hot-low
//     digit_idx_o    out  IDX_W        slot index in progress
// ---------------------------------------------------------------------------
module ssd_scan_ctrl #(
    parameter int digits_p           = 4,
    parameter int cycles_per_digit_p = 1000,
    parameter int blank_cycles_p     = 16,
    localparam int IDX_W = (digits_p > 1) ? $clog2(digits_p) : 1
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  en_i,
    input  logic [4*digits_p-1:0] value_i,
    input  logic [digits_p-1:0]   dp_i,
    input  logic                  lz_suppress_i,
    output logic [6:0]            ssd_o,
    output logic                  dp_o,
    output logic [digits_p-1:0]   an_o,
    output logic [IDX_W-1:0]      digit_idx_o
);

    import ssd_pkg::*;

    localparam int CNT_W = (cycles_per_digit_p > 1) ? $clog2(cycles_per_digit_p) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(digits_p - 1);
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(cycles_per_digit_p - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(blank_cycles_p - 1);

    scan_state_e           state_q, state_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [4*digits_p-1:0] snap_q, snap_d;
    logic [digits_p-1:0]   snap_dp_q, snap_dp_d;
    logic                  snap_lz_q, snap_lz_d;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    // NOTE: every variable gets a default at the top of the block so no
    // path leaves it unassigned; otherwise a latch would be inferred.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        snap_d    = snap_q;
        snap_dp_d = snap_dp_q;
        snap_lz_d = snap_lz_q;

        if (!en_i) begin
            // Abandon any partial slot; re-enable restarts at digit 0.
            state_d = ST_IDLE;
            idx_d   = '0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    snap_d    = value_i;
                    snap_dp_d = dp_i;
                    snap_lz_d = lz_suppress_i;
                    state_d   = ST_BLANK;
                    idx_d     = '0;
                    cnt_d     = '0;
                end
                ST_BLANK: begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == BLANK_LAST) begin
                        state_d = ST_SHOW;
                    end
                end
                ST_SHOW: begin
                    if (cnt_q == CNT_LAST) begin
                        state_d = ST_BLANK;
                        cnt_d   = '0;
                        if (idx_q == IDX_LAST) begin
                            // Frame boundary: take a fresh snapshot.
                            idx_d     = '0;
                            snap_d    = value_i;
                            snap_dp_d = dp_i;
                            snap_lz_d = lz_suppress_i;
                        end else begin
                            idx_d = idx_q + IDX_W'(1);
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    idx_d   = '0;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every
    // register samples the pre-edge values of the others.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            cnt_q     <= '0;
            // NOTE: the snapshot is plain data, but it is reset anyway so a
            // fresh part never decodes undefined nibbles.
            snap_q    <= '0;
            snap_dp_q <= '0;
            snap_lz_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            snap_q    <= snap_d;
            snap_dp_q <= snap_dp_d;
            snap_lz_q <= snap_lz_d;
        end
    end

    // ------------------------------------------------------------------
    // Digit selection and leading-zero detection
    // ------------------------------------------------------------------
    logic [3:0] sel_nib;
    logic       sel_dp;
    logic       sel_zero_up;   // selected nibble and all above it are zero
    logic       zero_run;

    // Walk from the top digit down; zero_run holds "nibbles i..top all zero".
    always_comb begin
        sel_nib     = 4'h0;
        sel_dp      = 1'b0;
        sel_zero_up = 1'b0;
        zero_run    = 1'b1;
        for (int i = digits_p - 1; i >= 0; i--) begin
            zero_run = zero_run & (snap_q[4*i +: 4] == 4'h0);
            if (idx_q == IDX_W'(i)) begin
                sel_nib     = snap_q[4*i +: 4];
                sel_dp      = snap_dp_q[i];
                sel_zero_up = zero_run;
            end
        end
    end

    logic       suppress;
    logic       lit;
    logic [6:0] dec_seg;

    assign suppress = snap_lz_q && (idx_q != '0) && sel_zero_up;
    assign lit      = (state_q == ST_SHOW) && !suppress;

    hex2ssd u_hex2ssd (
        .hex_i (sel_nib),
        .ssd_o (dec_seg)
    );

    // ------------------------------------------------------------------
    // Outputs (registers only, through the decoder)
    // ------------------------------------------------------------------
    always_comb begin
        for (int i = 0; i < digits_p; i++) begin
            an_o[i] = !(lit && (idx_q == IDX_W'(i)));
        end
    end

    assign ssd_o       = lit ? dec_seg : SSD_BLANK;
    assign dp_o        = lit ? ~sel_dp : 1'b1;
    assign digit_idx_o = idx_q;

endmodule : ssd_scan_ctrl

// File: tb/tb_ssd_scan_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ssd_scan_ctrl
//   Scoreboard bench: the stimulus thread pushes the expected outputs of each
//   cycle; a negedge monitor pops and compares them.
//   Configuration: 4 digits, 8 cycles per slot, 2 blank cycles (32-cycle frame).
// ---------------------------------------------------------------------------
module tb_ssd_scan_ctrl;

    localparam int DIG = 4;
    localparam int CPD = 8;
    localparam int BLK = 2;

    logic        clk_i;
    logic        reset_i;
    logic        en_i;
    logic [15:0] value_i;
    logic [3:0]  dp_i;
    logic        lz_suppress_i;
    logic [6:0]  ssd_o;
    logic        dp_o;
    logic [3:0]  an_o;
    logic [1:0]  digit_idx_o;

    ssd_scan_ctrl #(
        .digits_p           (DIG),
        .cycles_per_digit_p (CPD),
        .blank_cycles_p     (BLK)
    ) dut (
        .clk_i         (clk_i),
        .reset_i       (reset_i),
        .en_i          (en_i),
        .value_i       (value_i),
        .dp_i          (dp_i),
        .lz_suppress_i (lz_suppress_i),
        .ssd_o         (ssd_o),
        .dp_o          (dp_o),
        .an_o          (an_o),
        .digit_idx_o   (digit_idx_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int tests_run = 0;
    int tests_failed = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    typedef struct {
        int         id;
        logic [3:0] an;
        logic [6:0] ssd;
        logic       dp;
        logic [1:0] idx;
    } exp_t;

    exp_t sb_q[$];

    function automatic logic [6:0] seg7(input logic [3:0] n);
        case (n)
            4'h0: return 7'b1000000;  4'h1: return 7'b1111001;
            4'h2: return 7'b0100100;  4'h3: return 7'b0110000;
            4'h4: return 7'b0011001;  4'h5: return 7'b0010010;
            4'h6: return 7'b0000010;  4'h7: return 7'b1111000;
            4'h8: return 7'b0000000;  4'h9: return 7'b0010000;
            4'hA: return 7'b0001000;  4'hB: return 7'b0000011;
            4'hC: return 7'b1000110;  4'hD: return 7'b0100001;
            4'hE: return 7'b0000110;  default: return 7'b0001110;
        endcase
    endfunction

    // Monitor: compare one scoreboard entry per cycle, away from the active edge.
    always @(negedge clk_i) begin
        if (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            check($sformatf("c%0d_an", e.id),  32'(an_o),        32'(e.an));
            check($sformatf("c%0d_ssd", e.id), 32'(ssd_o),       32'(e.ssd));
            check($sformatf("c%0d_dp", e.id),  32'(dp_o),        32'(e.dp));
            check($sformatf("c%0d_idx", e.id), 32'(digit_idx_o), 32'(e.idx));
        end
    end

    task automatic push_dark(input int id, input logic [1:0] idx);
        exp_t e;
        e.id  = id;
        e.an  = 4'hF;
        e.ssd = 7'h7F;
        e.dp  = 1'b1;
        e.idx = idx;
        sb_q.push_back(e);
    endtask

    // Expect cycles 0..last_c of a frame showing snapshot (v, dpv, lz).
    // At cycle chg_c the inputs are changed to (nv, ndp, nlz).
    task automatic run_frame(input logic [15:0] v, input logic [3:0] dpv, input logic lz,
                             input int last_c, input int chg_c,
                             input logic [15:0] nv, input logic [3:0] ndp, input logic nlz,
                             input int fid);
        int   top_nz;
        exp_t e;
        top_nz = -1;
        for (int k = 0; k < DIG; k++)
            if (v[4*k +: 4] != 4'h0) top_nz = k;
        for (int c = 0; c <= last_c; c++) begin
            int  d;
            int  p;
            bit  sup;
            @(posedge clk_i);
            #1;
            d   = c / CPD;
            p   = c % CPD;
            sup = lz && (d != 0) && (d > top_nz);
            if (p >= BLK && !sup) begin
                e.id  = fid * 100 + c;
                e.an  = ~(4'b0001 << d);
                e.ssd = seg7(v[4*d +: 4]);
                e.dp  = ~dpv[d];
                e.idx = d[1:0];
                sb_q.push_back(e);
            end else begin
                push_dark(fid * 100 + c, d[1:0]);
            end
            if (c == chg_c) begin
                value_i       = nv;
                dp_i          = ndp;
                lz_suppress_i = nlz;
            end
        end
    endtask

    initial begin
        reset_i       = 1'b1;
        en_i          = 1'b1;
        value_i       = 16'h12AF;
        dp_i          = 4'b0100;
        lz_suppress_i = 1'b0;

        // Reset held with enable high: dark, index 0.
        repeat (2) begin
            @(negedge clk_i);
            check("rst_an",  32'(an_o),        32'hF);
            check("rst_ssd", 32'(ssd_o),       32'h7F);
            check("rst_dp",  32'(dp_o),        32'h1);
            check("rst_idx", 32'(digit_idx_o), 32'h0);
        end

        // Release between edges: IDLE until the next edge, then frames start.
        reset_i = 1'b0;
        #1;
        check("idle_an",  32'(an_o),  32'hF);
        check("idle_ssd", 32'(ssd_o), 32'h7F);

        // Plain frame of 12AF, dp on digit 2.
        run_frame(16'h12AF, 4'b0100, 1'b0, 31, -1, 16'h0, 4'h0, 1'b0, 1);
        // Same frame, value torn to 3333 during digit 1 SHOW: snapshot holds.
        run_frame(16'h12AF, 4'b0100, 1'b0, 31, 12, 16'h3333, 4'b0000, 1'b0, 2);
        // Next frame shows 3333; then move to leading-zero tests.
        run_frame(16'h3333, 4'b0000, 1'b0, 31, 31, 16'h0050, 4'b1000, 1'b1, 3);
        // 0050 with suppression: digits 3 and 2 dark (dp request on 3 ignored).
        run_frame(16'h0050, 4'b1000, 1'b1, 31, 31, 16'h0000, 4'b0000, 1'b1, 4);
        // All zero with suppression: only digit 0 lights.
        run_frame(16'h0000, 4'b0000, 1'b1, 31, 31, 16'h12AF, 4'b0100, 1'b0, 5);

        // Disable for one cycle mid-SHOW of digit 2.
        run_frame(16'h12AF, 4'b0100, 1'b0, 20, -1, 16'h0, 4'h0, 1'b0, 6);
        en_i = 1'b0;
        @(posedge clk_i);
        #1;
        push_dark(700, 2'd0);
        en_i          = 1'b1;
        value_i       = 16'hBEEF;
        dp_i          = 4'b0001;
        lz_suppress_i = 1'b0;
        // Restart at digit 0 with a fresh snapshot.
        run_frame(16'hBEEF, 4'b0001, 1'b0, 31, -1, 16'h0, 4'h0, 1'b0, 8);

        // Asynchronous reset pulse between edges during digit 1 SHOW.
        run_frame(16'hBEEF, 4'b0001, 1'b0, 13, -1, 16'h0, 4'h0, 1'b0, 9);
        @(negedge clk_i);
        #1;
        check("pre_arst_an", 32'(an_o), 32'hD);
        #1;
        reset_i = 1'b1;
        #1;
        check("arst_an",  32'(an_o),        32'hF);
        check("arst_ssd", 32'(ssd_o),       32'h7F);
        check("arst_dp",  32'(dp_o),        32'h1);
        check("arst_idx", 32'(digit_idx_o), 32'h0);
        #1;
        reset_i = 1'b0;
        // Recovery: full frame from digit 0.
        run_frame(16'hBEEF, 4'b0001, 1'b0, 31, -1, 16'h0, 4'h0, 1'b0, 10);

        @(negedge clk_i);
        #1;
        check("sb_drain", 32'(sb_q.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule : tb_ssd_scan_ctrl
